bitty_core_pipe: RTL and testbench
==================================

Name: bitty_core_pipe

Overview:
- Parametrised successor to the fixed "+1 accumulator" core.
- Executes externally supplied 16-bit Bitty instructions on an 8-entry, WIDTH-bit register file.
- Uses a 4-state multi-cycle FSM (IDLE, LOAD, EXEC, WB) and a valid/ready instruction handshake.
- Sits between an instruction source (fetch unit or testbench) and the system. A completion pulse, the result and a debug read port are exposed for checking.

Parameters:
- WIDTH, 16, datapath and register width. Legal values are 8 to 32.
- IMM_SEXT, 0, selects how imm8 is extended to WIDTH: 0 = zero-extend, 1 = sign-extend.

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- instr  in  16  instruction word; sampled only on an accepting edge
- instr_valid  in  1  source has a valid instruction on instr
- instr_ready  out  1  core can accept an instruction; equals (state==IDLE)
- result  out  WIDTH  value written by the most recent writeback; holds until the next writeback
- done  out  1  one-cycle pulse, high in the cycle after each writeback
- state  out  2  FSM state: IDLE=0, LOAD=1, EXEC=2, WB=3
- dbg_addr  in  3  debug register-file read address
- dbg_data  out  WIDTH  combinational read of R[dbg_addr]

Behaviour:
- Reset (synchronous), all take effect on the edge where reset=1:
  - R[0..7], A, B, C and result all go to 0.
  - done=0, state=IDLE.
  - Reset overrides every other event, including an accept or a WB write on the same edge.
  - Reset mid-instruction aborts it: no writeback, no done pulse.
- Instruction format:
  - instr[1:0] selects the format.
  - fmt 00 (R): rx=[15:13], ry=[12:10], op=[4:2].
  - fmt 01 (I): rx=[15:13], imm8=[12:5], op=[4:2].
  - fmt 1x: NOP. It still takes the full 4 states but performs no register write. done still pulses; result is unchanged.
- Handshake:
  - Accept occurs on an edge where instr_valid && instr_ready. instr is latched into IR; IDLE -> LOAD.
  - instr_valid while not ready is ignored. The source must hold instr stable until accepted.
- FSM, with accept at edge E:
  - E: IR <= instr, state -> LOAD.
  - E+1 (LOAD): A <= R[rx]; B <= R[ry] for fmt 00, or extended imm8 for fmt 01; state -> EXEC.
  - E+2 (EXEC): C <= ALU(op, A, B); state -> WB.
  - E+3 (WB): if not NOP, R[rx] <= C and result <= C; done <= 1; state -> IDLE.
  - done is high for exactly the cycle after E+3 and is cleared on the next edge.
  - instr_ready is high again after E+3, so the next accept can occur at E+4. Peak throughput is 1 instruction per 4 cycles.
- ALU (unsigned, mod 2^WIDTH, no flags):
  - 000 add: A+B
  - 001 sub: A-B (wraps)
  - 010 and, 011 or, 100 xor
  - 101 shl: A<<B
  - 110 shr: A>>B, logical
  - Shifts: if B >= WIDTH the result is 0.
  - 111 cmp: 0 if A==B, 1 if A>B, 2 if A<B (unsigned); written to rx like any other op.
- Register file and debug port:
  - rx==ry is legal; the operand is read once in LOAD.
  - dbg_data reflects the register contents before any WB write on the current edge; the new value is visible the following cycle.
- Back-to-back dependency: instruction N+1 reads the value written by N because its LOAD occurs at or after E+5. No forwarding is needed.

Test Plan:
- Reset: assert reset 2 cycles -> state=0, instr_ready=1, done=0, result=0, dbg_data=0 for all 8 addresses. Then pulse instr_valid with reset held high -> still IDLE.
- Immediate and latency: with WIDTH=16, send fmt 01 rx=1 imm8=0xFF op=add, accepted at edge E.
  - Expected: state sequence 1,2,3,0; done=1 only in the cycle after E+3; R1=0x00FF; result=0x00FF.
  - With IMM_SEXT=1 the same instruction gives R1=0xFFFF.
- Arithmetic wrap and cmp:
  - R1=0x00FF, R2=0x0100 (loaded via immediates).
  - R-sub R1-R2 -> R1=0xFFFF.
  - cmp R1,R2 -> R1=1. cmp R2,R2 -> R2=0.
  - shl R2 by imm 16 -> 0. shl 0x0001 by 4 -> 0x0010.
- Handshake stress: hold instr_valid=1 continuously with 3 dependent adds (R3+=1 via imm).
  - Expected: exactly one accept per 4 cycles; R3 = 1, 2, 3; 3 done pulses; instr changed only after accept is honoured.
- Reset mid-op: accept add R4 += 5, assert reset in EXEC -> R4 stays 0, no done pulse, state=0 on the next cycle.
- NOP and width: send fmt 10 -> done pulses, no register changes, result unchanged. Rerun the arithmetic test with WIDTH=8: sub wraps to 0xFF and imm8 sign-extension is a no-op.

Source files
------------

// File: rtl/bitty_core_pipe.sv
// Multi-cycle Bitty core: accepts one 16-bit instruction at a time over a valid/ready handshake
// and steps it through LOAD, EXEC and WB against an 8-entry register file.
module bitty_core_pipe #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned IMM_SEXT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic [1:0]       state,
  input  logic [2:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StExec = 2'd2,
    StWb   = 2'd3
  } state_e;

  localparam logic [WIDTH-1:0] HiMask = ~(WIDTH'(8'hFF));

  state_e           state_q;
  logic [15:0]      ir_q;
  logic [WIDTH-1:0] rf_q [8];
  logic [WIDTH-1:0] a_q, b_q, c_q, result_q;
  logic             done_q;

  logic [2:0]       rx, ry, op;
  logic [7:0]       imm8;
  logic [1:0]       fmt;
  logic [WIDTH-1:0] imm_ext;
  logic [WIDTH-1:0] alu;
  logic             shift_oob;

  assign rx   = ir_q[15:13];
  assign ry   = ir_q[12:10];
  assign imm8 = ir_q[12:5];
  assign op   = ir_q[4:2];
  assign fmt  = ir_q[1:0];

  // Upper bits filled with imm8[7] only when sign extension is selected.
  assign imm_ext = WIDTH'(imm8) | ((IMM_SEXT != 0 && imm8[7]) ? HiMask : '0);

  always_comb begin
    alu       = '0;
    shift_oob = 32'(b_q) >= WIDTH;
    case (op)
      3'b000: alu = a_q + b_q;
      3'b001: alu = a_q - b_q;
      3'b010: alu = a_q & b_q;
      3'b011: alu = a_q | b_q;
      3'b100: alu = a_q ^ b_q;
      3'b101: alu = shift_oob ? '0 : (a_q << b_q);
      3'b110: alu = shift_oob ? '0 : (a_q >> b_q);
      default: begin
        if (a_q == b_q)     alu = '0;
        else if (a_q > b_q) alu = WIDTH'(1);
        else                alu = WIDTH'(2);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (instr_valid) begin
            ir_q    <= instr;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          a_q     <= rf_q[rx];
          b_q     <= (fmt == 2'b01) ? imm_ext : rf_q[ry];
          state_q <= StExec;
        end
        StExec: begin
          c_q     <= alu;
          state_q <= StWb;
        end
        StWb: begin
          // fmt 1x is a NOP: full sequence and done pulse, no architectural write.
          if (!fmt[1]) begin
            rf_q[rx] <= c_q;
            result_q <= c_q;
          end
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign instr_ready = (state_q == StIdle);
  assign state       = state_q;
  assign result      = result_q;
  assign done        = done_q;
  assign dbg_data    = rf_q[dbg_addr];

endmodule

// File: tb/tb_bitty_core_pipe.sv
// Directed bench: three cores (16-bit zero-ext, 16-bit sign-ext, 8-bit sign-ext) run the same
// instruction stream in lockstep, each checked against hand-computed register values.
module tb_bitty_core_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        instr_valid;
  logic [2:0]  dbg_addr;

  logic        ready_a, ready_s, ready_e;
  logic        done, done_s, done_e;
  logic [1:0]  state_a, state_s, state_e;
  logic [15:0] result_a, result_s, dbg_a, dbg_s;
  logic [7:0]  result_e, dbg_e;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bitty_core_pipe #(.WIDTH(16), .IMM_SEXT(0)) u_dut_a (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(ready_a), .result(result_a), .done(done), .state(state_a),
    .dbg_addr(dbg_addr), .dbg_data(dbg_a)
  );

  bitty_core_pipe #(.WIDTH(16), .IMM_SEXT(1)) u_dut_s (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(ready_s), .result(result_s), .done(done_s), .state(state_s),
    .dbg_addr(dbg_addr), .dbg_data(dbg_s)
  );

  bitty_core_pipe #(.WIDTH(8), .IMM_SEXT(1)) u_dut_e (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(ready_e), .result(result_e), .done(done_e), .state(state_e),
    .dbg_addr(dbg_addr), .dbg_data(dbg_e)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] enc_i(input logic [2:0] rx, input logic [7:0] imm,
                                        input logic [2:0] op);
    return {rx, imm, op, 2'b01};
  endfunction

  function automatic logic [15:0] enc_r(input logic [2:0] rx, input logic [2:0] ry,
                                        input logic [2:0] op);
    return {rx, ry, 5'b00000, op, 2'b00};
  endfunction

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic send(input logic [15:0] w);
    int n;
    n = 0;
    instr       = w;
    instr_valid = 1'b1;
    while (!ready_a && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (!ready_a) check_eq("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 12) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, {31'd0, done}, 32'd1);
    @(negedge clk);
  endtask

  task automatic run(input logic [15:0] w, input string tag);
    send(w);
    wait_done(tag);
  endtask

  task automatic chk_reg(input string tag, input logic [2:0] addr, input logic [15:0] ea,
                         input logic [15:0] es, input logic [7:0] ee);
    dbg_addr = addr;
    #1;
    check_eq({tag, "_w16z"}, {16'd0, dbg_a}, {16'd0, ea});
    check_eq({tag, "_w16s"}, {16'd0, dbg_s}, {16'd0, es});
    check_eq({tag, "_w8s"},  {24'd0, dbg_e}, {24'd0, ee});
  endtask

  initial begin
    int acc, dn, last, cnt;
    reset       = 1'b1;
    instr       = 16'h0000;
    instr_valid = 1'b0;
    dbg_addr    = 3'd0;

    // Reset state, then an offered instruction while reset is held.
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_state", {30'd0, state_a}, 32'd0);
    check_eq("rst_ready", {31'd0, ready_a}, 32'd1);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_result", {16'd0, result_a}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      check_eq("rst_rf", {16'd0, dbg_a}, 32'd0);
    end
    instr       = enc_i(3'd1, 8'h07, 3'd0);
    instr_valid = 1'b1;
    @(negedge clk);
    check_eq("rst_hold_state", {30'd0, state_a}, 32'd0);
    instr_valid = 1'b0;
    reset       = 1'b0;
    @(negedge clk);

    // Latency: addi R1, 0xFF.
    send(enc_i(3'd1, 8'hFF, 3'd0));
    check_eq("lat_load", {30'd0, state_a}, 32'd1);
    check_eq("lat_ready_busy", {31'd0, ready_a}, 32'd0);
    @(negedge clk);
    check_eq("lat_exec", {30'd0, state_a}, 32'd2);
    @(negedge clk);
    check_eq("lat_wb", {30'd0, state_a}, 32'd3);
    check_eq("lat_done_early", {31'd0, done}, 32'd0);
    @(negedge clk);
    check_eq("lat_idle", {30'd0, state_a}, 32'd0);
    check_eq("lat_done", {31'd0, done}, 32'd1);
    check_eq("lat_result", {16'd0, result_a}, 32'h00FF);
    @(negedge clk);
    check_eq("lat_done_clear", {31'd0, done}, 32'd0);
    chk_reg("imm_r1", 3'd1, 16'h00FF, 16'hFFFF, 8'hFF);

    // Wrap, cmp and shifts.
    run(enc_i(3'd2, 8'hFF, 3'd0), "done_r2a");
    run(enc_i(3'd2, 8'h01, 3'd0), "done_r2b");
    chk_reg("r2", 3'd2, 16'h0100, 16'h0000, 8'h00);
    run(enc_r(3'd1, 3'd2, 3'd1), "done_sub");
    chk_reg("sub", 3'd1, 16'hFFFF, 16'hFFFF, 8'hFF);
    run(enc_r(3'd1, 3'd2, 3'd7), "done_cmpgt");
    chk_reg("cmp_gt", 3'd1, 16'd1, 16'd1, 8'd1);
    run(enc_r(3'd2, 3'd2, 3'd7), "done_cmpeq");
    chk_reg("cmp_eq", 3'd2, 16'd0, 16'd0, 8'd0);
    run(enc_i(3'd5, 8'h01, 3'd0), "done_r5");
    run(enc_i(3'd5, 8'h04, 3'd5), "done_shl4");
    chk_reg("shl4", 3'd5, 16'h0010, 16'h0010, 8'h10);
    run(enc_r(3'd6, 3'd5, 3'd1), "done_subwrap");
    chk_reg("sub_wrap", 3'd6, 16'hFFF0, 16'hFFF0, 8'hF0);
    run(enc_i(3'd5, 8'h10, 3'd5), "done_shl16");
    chk_reg("shl16", 3'd5, 16'h0000, 16'h0000, 8'h00);
    run(enc_i(3'd6, 8'h3C, 3'd2), "done_and");
    chk_reg("and", 3'd6, 16'h0030, 16'h0030, 8'h30);
    run(enc_i(3'd6, 8'h05, 3'd3), "done_or");
    chk_reg("or", 3'd6, 16'h0035, 16'h0035, 8'h35);
    run(enc_i(3'd6, 8'hFF, 3'd4), "done_xor");
    chk_reg("xor", 3'd6, 16'h00CA, 16'hFFCA, 8'hCA);
    run(enc_i(3'd6, 8'h04, 3'd6), "done_shr");
    chk_reg("shr", 3'd6, 16'h000C, 16'h0FFC, 8'h0C);
    run(enc_i(3'd6, 8'h10, 3'd7), "done_cmplt");
    chk_reg("cmp_lt", 3'd6, 16'd2, 16'd1, 8'd2);
    check_eq("result_cmp", {16'd0, result_a}, 32'd2);

    // Handshake stress: valid held high across three dependent R3 += 1.
    dbg_addr    = 3'd3;
    instr       = enc_i(3'd3, 8'h01, 3'd0);
    instr_valid = 1'b1;
    acc  = 0;
    dn   = 0;
    last = 0;
    for (int c = 0; c < 24; c++) begin
      if (instr_valid && ready_a) begin
        acc++;
        if (acc > 1) check_eq("stress_gap", 32'(c - last), 32'd4);
        last = c;
      end
      if (done) begin
        dn++;
        check_eq("stress_r3", {16'd0, dbg_a}, 32'(dn));
      end
      @(negedge clk);
      if (acc == 3) instr_valid = 1'b0;
    end
    check_eq("stress_accepts", 32'(acc), 32'd3);
    check_eq("stress_dones", 32'(dn), 32'd3);

    // Reset during EXEC aborts the instruction.
    send(enc_i(3'd4, 8'h05, 3'd0));
    @(negedge clk);
    check_eq("abort_exec", {30'd0, state_a}, 32'd2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("abort_state", {30'd0, state_a}, 32'd0);
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (done) cnt++;
      @(negedge clk);
    end
    check_eq("abort_no_done", 32'(cnt), 32'd0);
    chk_reg("abort_r4", 3'd4, 16'd0, 16'd0, 8'd0);
    chk_reg("abort_r1", 3'd1, 16'd0, 16'd0, 8'd0);

    // NOP: done pulses, nothing changes.
    run(enc_i(3'd7, 8'h2A, 3'd0), "done_r7");
    run(16'hFFFE, "done_nop");
    check_eq("nop_result", {16'd0, result_a}, 32'h002A);
    chk_reg("nop_r7", 3'd7, 16'h002A, 16'h002A, 8'h2A);
    run(16'h0003, "done_nop0");
    chk_reg("nop_r0", 3'd0, 16'd0, 16'd0, 8'd0);
    check_eq("nop_result0", {24'd0, result_e}, 32'h2A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
